// File: rtl/word_block_stream_buffer.sv
// Word stream buffer that stores data as 4-word blocks.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   word_in, word_in_ready  - producer word and its valid
//   pull_word               - buffer accepts word_in this cycle
//   word_out, word_ready    - consumer word and its valid
//   word_out_hold           - consumer stall
//   fifo_full, fifo_empty   - block FIFO status flags
//   fifo_count              - blocks held in the block FIFO
module word_block_stream_buffer #(
   parameter int WSIZE   = 32,
   parameter int FIFOLEN = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WSIZE-1:0]           word_in,
   input  logic                       word_in_ready,
   output logic                       pull_word,
   output logic [WSIZE-1:0]           word_out,
   output logic                       word_ready,
   input  logic                       word_out_hold,
   output logic                       fifo_full,
   output logic                       fifo_empty,
   output logic [$clog2(FIFOLEN):0]   fifo_count
);

   localparam int BSIZE = 4 * WSIZE;
   localparam int PW    = $clog2(FIFOLEN);
   localparam int CW    = PW + 1;

   // ---------------------------------------------------------------
   // Assembler
   // ---------------------------------------------------------------
   logic [1:0]       widx;
   logic             staging_valid;
   logic [BSIZE-1:0] staging;
   logic             take;
   logic             push;

   assign pull_word = !staging_valid;
   assign take      = word_in_ready && pull_word;
   assign push      = staging_valid && !fifo_full;

   // Slot 0 is the most significant word of the block.
   always_ff @(posedge clock) begin
      if (reset) begin
         widx          <= 2'd0;
         staging_valid <= 1'b0;
         staging       <= '0;
      end else begin
         if (take) begin
            unique case (widx)
               2'd0: staging[4*WSIZE-1:3*WSIZE] <= word_in;
               2'd1: staging[3*WSIZE-1:2*WSIZE] <= word_in;
               2'd2: staging[2*WSIZE-1:WSIZE]   <= word_in;
               2'd3: staging[WSIZE-1:0]         <= word_in;
               default: ;
            endcase
            widx <= widx + 2'd1;
            if (widx == 2'd3) begin
               staging_valid <= 1'b1;
            end
         end
         // take and push are mutually exclusive: take needs
         // an empty staging register, push needs a full one.
         if (push) begin
            staging_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------
   // Block FIFO
   // ---------------------------------------------------------------
   logic [BSIZE-1:0] mem [FIFOLEN];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             pop;

   assign fifo_count = count;

   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Storage carries no reset; validity is tracked by count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= staging;
      end
   end

   // Flags are registered from the next count so they line up
   // with count itself.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         fifo_full  <= 1'b0;
         fifo_empty <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count      <= count_next;
         fifo_full  <= (count_next == CW'(FIFOLEN));
         fifo_empty <= (count_next == '0);
      end
   end

   // ---------------------------------------------------------------
   // Disassembler
   // ---------------------------------------------------------------
   logic             busy;
   logic [1:0]       didx;
   logic [BSIZE-1:0] block;
   logic             consume;
   logic             last;

   assign consume    = busy && !word_out_hold;
   assign last       = consume && (didx == 2'd3);
   // Reloading on the last consumed word keeps the stream gapless.
   assign pop        = (!busy || last) && !fifo_empty;
   assign word_ready = busy;

   always_ff @(posedge clock) begin
      if (reset) begin
         busy  <= 1'b0;
         didx  <= 2'd0;
         block <= '0;
      end else begin
         if (pop) begin
            block <= mem[rd_ptr];
            busy  <= 1'b1;
            didx  <= 2'd0;
         end else if (consume) begin
            didx <= didx + 2'd1;
            if (didx == 2'd3) begin
               busy <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      word_out = '0;
      if (busy) begin
         unique case (didx)
            2'd0: word_out = block[4*WSIZE-1:3*WSIZE];
            2'd1: word_out = block[3*WSIZE-1:2*WSIZE];
            2'd2: word_out = block[2*WSIZE-1:WSIZE];
            2'd3: word_out = block[WSIZE-1:0];
            default: word_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_word_block_stream_buffer.sv
// Directed bench for word_block_stream_buffer.
// Ports: none; drives the DUT and prints one summary line.
module tb_word_block_stream_buffer;

   logic        clock;
   logic        reset;
   logic [31:0] word_in;
   logic        word_in_ready;
   logic        pull_word;
   logic [31:0] word_out;
   logic        word_ready;
   logic        word_out_hold;
   logic        fifo_full;
   logic        fifo_empty;
   logic [3:0]  fifo_count;

   int errors = 0;
   int checks = 0;

   word_block_stream_buffer #(
      .WSIZE(32),
      .FIFOLEN(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .word_in(word_in),
      .word_in_ready(word_in_ready),
      .pull_word(pull_word),
      .word_out(word_out),
      .word_ready(word_ready),
      .word_out_hold(word_out_hold),
      .fifo_full(fifo_full),
      .fifo_empty(fifo_empty),
      .fifo_count(fifo_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_pull"}, pull_word, 1);
      check({tag, "_ready"}, word_ready, 0);
      check({tag, "_empty"}, fifo_empty, 1);
      check({tag, "_full"}, fifo_full, 0);
      check({tag, "_count"}, fifo_count, 0);
      check({tag, "_out"}, word_out, 0);
   endtask

   task automatic push_word(input logic [31:0] w);
      int  n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      word_in       = w;
      word_in_ready = 1'b1;
      while (!acc && n < 20) begin
         acc = pull_word;
         step();
         n++;
      end
      word_in_ready = 1'b0;
      check("accept", acc, 1);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!word_ready && n < 10) begin
         step();
         n++;
      end
      check("ready_wait", word_ready, 1);
   endtask

   logic [31:0] s2 [4];
   logic [31:0] s5 [4];
   logic [31:0] s6 [4];

   initial begin
      int acc;
      logic a;
      logic seen;
      s2 = '{32'h0000C0D1, 32'h0000D0C1, 32'h0000E0F1, 32'h0000F0E1};
      s5 = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h12123434};
      s6 = '{32'hB0B0_0001, 32'hB0B0_0002, 32'hB0B0_0003, 32'hB0B0_0004};

      reset         = 1'b1;
      word_in       = '0;
      word_in_ready = 1'b0;
      word_out_hold = 1'b0;
      step();
      step();
      check_idle("rst_in");
      reset = 1'b0;
      step();
      check_idle("rst_out");

      // Simple 4-word stream, latency and order.
      for (int i = 0; i < 4; i++) push_word(s2[i]);
      check("s2_pull_lo", pull_word, 0);
      check("s2_rdy_n1", word_ready, 0);
      step();
      check("s2_rdy_n2", word_ready, 0);
      check("s2_cnt_n2", fifo_count, 1);
      check("s2_empty_n2", fifo_empty, 0);
      check("s2_pull_n2", pull_word, 1);
      step();
      check("s2_empty_n3", fifo_empty, 1);
      for (int i = 0; i < 4; i++) begin
         check("s2_rdy", word_ready, 1);
         check($sformatf("s2_w%0d", i), word_out, s2[i]);
         step();
      end
      check("s2_done_rdy", word_ready, 0);
      check("s2_done_empty", fifo_empty, 1);
      check("s2_done_out", word_out, 0);

      // Fill to capacity with the consumer stalled.
      word_out_hold = 1'b1;
      acc = 0;
      for (int c = 0; c < 80; c++) begin
         if (acc < 48) begin
            word_in       = acc;
            word_in_ready = 1'b1;
         end else begin
            word_in_ready = 1'b0;
         end
         a = pull_word && word_in_ready;
         step();
         if (a) acc++;
      end
      word_in_ready = 1'b0;
      check("fill_accepted", acc, 40);
      check("fill_pull", pull_word, 0);
      check("fill_full", fifo_full, 1);
      check("fill_count", fifo_count, 8);
      check("fill_rdy", word_ready, 1);
      check("fill_out", word_out, 0);
      step();
      check("fill_out_held", word_out, 0);

      // Drain: gapless 0..39.
      word_out_hold = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         check($sformatf("drain_rdy%0d", k), word_ready, 1);
         check($sformatf("drain_w%0d", k), word_out, k);
         if (pull_word) seen = 1'b1;
         step();
      end
      check("drain_pull_seen", seen, 1);
      check_idle("drain_end");

      // One-cycle hold on the second word.
      for (int i = 0; i < 4; i++) push_word(s5[i]);
      wait_ready();
      check("h_w0", word_out, s5[0]);
      step();
      check("h_w1", word_out, s5[1]);
      word_out_hold = 1'b1;
      step();
      check("h_w1_held", word_out, s5[1]);
      check("h_rdy_held", word_ready, 1);
      word_out_hold = 1'b0;
      step();
      check("h_w2", word_out, s5[2]);
      step();
      check("h_w3", word_out, s5[3]);
      step();
      check("h_done", word_ready, 0);

      // Reset mid-stream discards everything.
      for (int i = 0; i < 6; i++) push_word(32'hA0A0_0000 + i);
      reset = 1'b1;
      step();
      check_idle("mid_rst");
      reset = 1'b0;
      step();
      check_idle("post_rst");
      for (int i = 0; i < 4; i++) push_word(s6[i]);
      wait_ready();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fresh_w%0d", i), word_out, s6[i]);
         step();
      end
      check("fresh_done_rdy", word_ready, 0);
      check("fresh_done_empty", fifo_empty, 1);
      step();
      step();
      check("fresh_no_stale", word_ready, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/word_block_stream_buffer.md
Name: word_block_stream_buffer

Overview:
Elastic word-stream buffer that stores data internally as 4-word blocks. An assembler packs incoming words into 4*WSIZE blocks. The blocks go through a synchronous block FIFO. A disassembler then splits each block back into words. Word order is preserved end to end. It sits between a word producer and a word consumer and decouples their rates by up to FIFOLEN+2 blocks.

Parameters:
WSIZE, 32, word width in bits; block width is 4*WSIZE.
FIFOLEN, 8, FIFO depth in blocks; must be a power of 2 and at least 2.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
word_in  in  WSIZE  input word.
word_in_ready  in  1  word_in is valid this cycle.
pull_word  out  1  buffer accepts word_in this cycle; the transfer happens when word_in_ready && pull_word.
word_out  out  WSIZE  current output word.
word_ready  out  1  word_out is valid.
word_out_hold  in  1  consumer stall; while high, word_out is not consumed.
fifo_full  out  1  block FIFO holds FIFOLEN blocks.
fifo_empty  out  1  block FIFO holds 0 blocks.
fifo_count  out  $clog2(FIFOLEN)+1  number of blocks in the FIFO.

Behaviour:
- Interface: one clock named clock; reset is synchronous and active-high, named reset.
- Reset: assembler word index=0, staging valid=0; FIFO rd/wr pointers=0, count=0; disassembler busy=0, index=0.
  - Output values during and after reset: word_out=0, word_ready=0, pull_word=1, fifo_empty=1, fifo_full=0, fifo_count=0.
  - Reset mid-operation discards all buffered data.
- Block packing: slot 0 (the first word) is bits [4*WSIZE-1:3*WSIZE]; slot 3 is bits [WSIZE-1:0]. MSB-first.
- Assembler:
  - pull_word = !staging_valid (combinational).
  - On a transfer, word_in is written to slot[widx] and widx increments.
  - When widx==3 on a transfer: widx<=0 and staging_valid<=1.
  - When staging_valid && !fifo_full: push the staged block into the FIFO and set staging_valid<=0. pull_word therefore rises on the following cycle.
  - A partial block (fewer than 4 words) is never pushed; it waits for more words.
- FIFO:
  - Circular buffer of FIFOLEN blocks; pointers wrap modulo FIFOLEN.
  - A push when full is ignored; a pop when empty is ignored.
  - Simultaneous push and pop in the same cycle: both take effect and the count is unchanged. The FIFO is never full at the point it is pushed by construction.
  - Flags and count are registered from the count value.
- Disassembler:
  - Load condition: (!busy || (busy && !word_out_hold && didx==3)) && !fifo_empty.
  - On load: pop one block, latch it, set busy<=1, didx<=0.
  - word_ready = busy; word_out = slot[didx] of the latched block, or 0 when not busy.
  - When busy && !word_out_hold: the word is consumed that cycle and didx increments.
  - After didx==3 is consumed, it reloads the next block in the same cycle if one is available, giving a gapless stream. Otherwise busy<=0.
  - While word_out_hold=1: word_out, didx and word_ready stay frozen.
- Latency (empty buffer, no hold):
  - The 4th word is accepted at edge N; the push happens at N+1; the load happens at N+2.
  - The first word_out is valid after N+2, and subsequent words follow one per clock.
- Capacity: 1 block in the disassembler + FIFOLEN blocks in the FIFO + 1 staged block = (FIFOLEN+2)*4 words before pull_word stays low.
- Arithmetic: all counters wrap naturally; no data width conversion beyond slot selection.

Test Plan:
- Reset -> pull_word=1, word_ready=0, fifo_empty=1, fifo_count=0, word_out=0.
- Stream words 0x0000C0D1, 0x0000D0C1, 0x0000E0F1, 0x0000F0E1 with hold=0 -> word_ready rises 2 clocks after the 4th accept; word_out shows the same 4 values on 4 consecutive clocks; then word_ready=0 and fifo_empty=1.
- word_out_hold=1 throughout, offer words 0..47 (FIFOLEN=8) -> exactly 40 words accepted, pull_word=0 after word 39, fifo_full=1, fifo_count=8, word_out=0 held.
- Continue that case: release hold -> word_out emits 0..39 in order, one per clock with no gaps; pull_word re-asserts as blocks drain; the final state is empty.
- Assert word_out_hold for 1 cycle mid-block (at the 2nd word of block 0x1111_2222_3333_4444_5555_6666_1212_3434 with WSIZE=32) -> the word stays 0x33334444 for 2 clocks and the sequence is otherwise unchanged.
- Assert reset mid-stream after 6 accepted words -> all outputs return to their reset values; the next 4 words come out as a fresh block with no stale data.
